alarm_controller: RTL and testbench



---
 rtl/alarm_controller.sv | 258 +++++++++++++++++++++++++
 tb/tb_alarm_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// alarm_controller
//   Alarm scheduler for the century clock. Holds a BCD alarm time (hh:mm),
//   compares it against the live time counters and sequences ring / stop /
//   snooze behaviour. All outputs are registered.
//
//   Optional feature macro: ALARM_SNOOZE_EN
//     defined   -> snooze input accepted, SNOOZE state and counters present
//     undefined -> snooze ignored, snoozing tied low, only stop/timeout end a ring
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     tick_1hz              one-cycle strobe per second
//     alarm_on              level, arms the alarm
//     set_mode              level, up/down/sel edit the alarm time
//     sel, up, down         one-cycle edit pulses
//     stop, snooze          one-cycle control pulses
//     hour_ten..sec_unit    live BCD time
//     al_*                  alarm time, BCD
//     set_field             0 = minute field selected, 1 = hour field
//     ringing, snoozing     state decode
//     buzzer                ringing AND beep phase
module alarm_controller #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       alarm_on,
  input  logic       set_mode,
  input  logic       sel,
  input  logic       up,
  input  logic       down,
  input  logic       stop,
  input  logic       snooze,
  input  logic [1:0] hour_ten,
  input  logic [3:0] hour_unit,
  input  logic [3:0] min_ten,
  input  logic [3:0] min_unit,
  input  logic [3:0] sec_ten,
  input  logic [3:0] sec_unit,
  output logic [1:0] al_hour_ten,
  output logic [3:0] al_hour_unit,
  output logic [3:0] al_min_ten,
  output logic [3:0] al_min_unit,
  output logic       set_field,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  typedef enum logic [1:0] {ST_OFF, ST_ARMED, ST_RINGING, ST_SNOOZE} state_t;

  localparam logic [7:0] LP_RING_SEC = 8'(RING_SEC);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_ring_cnt, w_ring_cnt_nxt;
  logic       r_beep, w_beep_nxt;
  logic       r_match_q;
  logic       r_ringing, r_buzzer;
  logic       r_set_field;
  logic [1:0] r_al_ht, w_al_ht_nxt;
  logic [3:0] r_al_hu, w_al_hu_nxt;
  logic [3:0] r_al_mt, w_al_mt_nxt;
  logic [3:0] r_al_mu, w_al_mu_nxt;

  logic w_match, w_trigger, w_do_up, w_do_dn, w_do_sel;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] LP_SNOOZE_SEC = 10'(SNOOZE_SEC);
  localparam logic [2:0] LP_MAX_SNOOZE = 3'(MAX_SNOOZE);
  logic [9:0] r_snz_cnt, w_snz_cnt_nxt;
  logic [2:0] r_snz_num, w_snz_num_nxt;
  logic       r_snoozing;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = ^{snooze, 10'(SNOOZE_SEC), 3'(MAX_SNOOZE)};
`endif

  // Full-digit equality: out-of-range live digits only match identical alarm digits.
  assign w_match = (hour_ten == r_al_ht) && (hour_unit == r_al_hu) &&
                   (min_ten == r_al_mt) && (min_unit == r_al_mu) &&
                   (sec_ten == 4'd0) && (sec_unit == 4'd0);
  assign w_trigger = w_match & ~r_match_q;

  assign w_do_up  = set_mode & up & ~down;
  assign w_do_dn  = set_mode & down & ~up;
  assign w_do_sel = set_mode & sel;

  // Alarm time edit; acts on the field selected before any same-cycle sel.
  always_comb begin
    w_al_ht_nxt = r_al_ht;
    w_al_hu_nxt = r_al_hu;
    w_al_mt_nxt = r_al_mt;
    w_al_mu_nxt = r_al_mu;
    if (w_do_up) begin
      if (!r_set_field) begin
        if (r_al_mu == 4'd9) begin
          w_al_mu_nxt = '0;
          w_al_mt_nxt = (r_al_mt == 4'd5) ? 4'd0 : r_al_mt + 4'd1;
        end else begin
          w_al_mu_nxt = r_al_mu + 4'd1;
        end
      end else begin
        if (r_al_ht == 2'd2 && r_al_hu == 4'd3) begin
          w_al_ht_nxt = '0;
          w_al_hu_nxt = '0;
        end else if (r_al_hu == 4'd9) begin
          w_al_hu_nxt = '0;
          w_al_ht_nxt = r_al_ht + 2'd1;
        end else begin
          w_al_hu_nxt = r_al_hu + 4'd1;
        end
      end
    end else if (w_do_dn) begin
      if (!r_set_field) begin
        if (r_al_mu == 4'd0) begin
          w_al_mu_nxt = 4'd9;
          w_al_mt_nxt = (r_al_mt == 4'd0) ? 4'd5 : r_al_mt - 4'd1;
        end else begin
          w_al_mu_nxt = r_al_mu - 4'd1;
        end
      end else begin
        if (r_al_ht == 2'd0 && r_al_hu == 4'd0) begin
          w_al_ht_nxt = 2'd2;
          w_al_hu_nxt = 4'd3;
        end else if (r_al_hu == 4'd0) begin
          w_al_hu_nxt = 4'd9;
          w_al_ht_nxt = r_al_ht - 2'd1;
        end else begin
          w_al_hu_nxt = r_al_hu - 4'd1;
        end
      end
    end
  end

  // Next-state logic. The set_mode abort applies only to RINGING/SNOOZE so that
  // editing the alarm onto the current minute can still trigger from ARMED.
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_beep_nxt     = r_beep;
`ifdef ALARM_SNOOZE_EN
    w_snz_cnt_nxt  = r_snz_cnt;
    w_snz_num_nxt  = r_snz_num;
`endif
    if (!alarm_on) begin
      w_state_nxt = ST_OFF;
      w_beep_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_OFF: w_state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (w_trigger) begin
            w_state_nxt    = ST_RINGING;
            w_ring_cnt_nxt = LP_RING_SEC;
            w_beep_nxt     = 1'b1;
`ifdef ALARM_SNOOZE_EN
            w_snz_num_nxt  = '0;
`endif
          end
        end
        ST_RINGING: begin
          if (set_mode || stop) begin
            w_state_nxt = ST_ARMED;
            w_beep_nxt  = 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze && (r_snz_num < LP_MAX_SNOOZE)) begin
            w_state_nxt   = ST_SNOOZE;
            w_snz_cnt_nxt = LP_SNOOZE_SEC;
            w_snz_num_nxt = r_snz_num + 3'd1;
            w_beep_nxt    = 1'b0;
`endif
          end else if (tick_1hz) begin
            if (r_ring_cnt == 8'd1) begin
              w_state_nxt = ST_ARMED;
              w_beep_nxt  = 1'b0;
            end else begin
              w_ring_cnt_nxt = r_ring_cnt - 8'd1;
              w_beep_nxt     = ~r_beep;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (set_mode || stop) begin
            w_state_nxt = ST_ARMED;
          end else if (tick_1hz) begin
            if (r_snz_cnt == 10'd1) begin
              w_state_nxt    = ST_RINGING;
              w_ring_cnt_nxt = LP_RING_SEC;
              w_beep_nxt     = 1'b1;
            end else begin
              w_snz_cnt_nxt = r_snz_cnt - 10'd1;
            end
          end
        end
`endif
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they follow the
  // causing input by exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OFF;
      r_ring_cnt  <= '0;
      r_beep      <= 1'b0;
      r_match_q   <= 1'b0;
      r_ringing   <= 1'b0;
      r_buzzer    <= 1'b0;
      r_set_field <= 1'b0;
      r_al_ht     <= '0;
      r_al_hu     <= '0;
      r_al_mt     <= '0;
      r_al_mu     <= '0;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt   <= '0;
      r_snz_num   <= '0;
      r_snoozing  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ring_cnt  <= w_ring_cnt_nxt;
      r_beep      <= w_beep_nxt;
      r_match_q   <= w_match;
      r_ringing   <= (w_state_nxt == ST_RINGING);
      r_buzzer    <= (w_state_nxt == ST_RINGING) & w_beep_nxt;
      r_set_field <= r_set_field ^ w_do_sel;
      r_al_ht     <= w_al_ht_nxt;
      r_al_hu     <= w_al_hu_nxt;
      r_al_mt     <= w_al_mt_nxt;
      r_al_mu     <= w_al_mu_nxt;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt   <= w_snz_cnt_nxt;
      r_snz_num   <= w_snz_num_nxt;
      r_snoozing  <= (w_state_nxt == ST_SNOOZE);
`endif
    end
  end

  assign al_hour_ten  = r_al_ht;
  assign al_hour_unit = r_al_hu;
  assign al_min_ten   = r_al_mt;
  assign al_min_unit  = r_al_mu;
  assign set_field    = r_set_field;
  assign ringing      = r_ringing;
  assign buzzer       = r_buzzer;
`ifdef ALARM_SNOOZE_EN
  assign snoozing     = r_snoozing;
`else
  assign snoozing     = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, alarm_on = 1'b0, set_mode = 1'b0;
  logic       sel = 1'b0, up = 1'b0, down = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [1:0] hour_ten = 2'd1;
  logic [3:0] hour_unit = 4'd2, min_ten = 4'd3, min_unit = 4'd4;
  logic [3:0] sec_ten = 4'd5, sec_unit = 4'd6;
  logic [1:0] al_hour_ten;
  logic [3:0] al_hour_unit, al_min_ten, al_min_unit;
  logic       set_field, ringing, snoozing, buzzer;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_controller #(
    .RING_SEC   (60),
    .SNOOZE_SEC (5),
    .MAX_SNOOZE (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .alarm_on     (alarm_on),
    .set_mode     (set_mode),
    .sel          (sel),
    .up           (up),
    .down         (down),
    .stop         (stop),
    .snooze       (snooze),
    .hour_ten     (hour_ten),
    .hour_unit    (hour_unit),
    .min_ten      (min_ten),
    .min_unit     (min_unit),
    .sec_ten      (sec_ten),
    .sec_unit     (sec_unit),
    .al_hour_ten  (al_hour_ten),
    .al_hour_unit (al_hour_unit),
    .al_min_ten   (al_min_ten),
    .al_min_unit  (al_min_unit),
    .set_field    (set_field),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .buzzer       (buzzer)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change just after a falling edge; one rising edge sees them.
  task automatic pulse(input logic p_sel, input logic p_up, input logic p_dn,
                       input logic p_stop, input logic p_snz, input logic p_tick);
    sel = p_sel; up = p_up; down = p_dn; stop = p_stop; snooze = p_snz; tick_1hz = p_tick;
    @(negedge clk);
    sel = 0; up = 0; down = 0; stop = 0; snooze = 0; tick_1hz = 0;
  endtask

  task automatic set_time(input logic [1:0] ht, input logic [3:0] hu, input logic [3:0] mt,
                          input logic [3:0] mu, input logic [3:0] st, input logic [3:0] su);
    hour_ten = ht; hour_unit = hu; min_ten = mt; min_unit = mu; sec_ten = st; sec_unit = su;
    @(negedge clk);
  endtask

  task automatic make_ring;
    set_time(2'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd9);
    set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({al_hour_ten, al_hour_unit, al_min_ten, al_min_unit} !== 14'd0) begin
      n_fail++; $display("FAIL reset_alarm got %h exp 0000", {al_hour_ten, al_hour_unit, al_min_ten, al_min_unit});
    end
    n_checks++;
    if ({set_field, ringing, snoozing, buzzer} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {set_field, ringing, snoozing, buzzer});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_edit;
    alarm_on = 1'b1;
    set_mode = 1'b1;
    @(negedge clk);
    pulse(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (set_field !== 1'b1) begin n_fail++; $display("FAIL sel_to_hour got %b exp 1", set_field); end
    repeat (7) pulse(0, 1, 0, 0, 0, 0);
    n_checks++;
    if ({al_hour_ten, al_hour_unit} !== {2'd0, 4'd7}) begin
      n_fail++; $display("FAIL hour_07 got %h%h exp 07", al_hour_ten, al_hour_unit);
    end
    pulse(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (set_field !== 1'b0) begin n_fail++; $display("FAIL sel_to_min got %b exp 0", set_field); end
    repeat (3) pulse(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({al_min_ten, al_min_unit} !== {4'd5, 4'd7}) begin
      n_fail++; $display("FAIL min_dn_wrap got %h%h exp 57", al_min_ten, al_min_unit);
    end
    repeat (3) pulse(0, 1, 0, 0, 0, 0);
    n_checks++;
    if ({al_min_ten, al_min_unit} !== {4'd0, 4'd0}) begin
      n_fail++; $display("FAIL min_up_wrap got %h%h exp 00", al_min_ten, al_min_unit);
    end
    repeat (30) pulse(0, 1, 0, 0, 0, 0);
    n_checks++;
    if ({al_hour_ten, al_hour_unit, al_min_ten, al_min_unit} !== {2'd0, 4'd7, 4'd3, 4'd0} || set_field !== 1'b0) begin
      n_fail++; $display("FAIL alarm_0730 got %h%h:%h%h f%b exp 07:30 f0",
                         al_hour_ten, al_hour_unit, al_min_ten, al_min_unit, set_field);
    end
    set_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ring;
    set_time(2'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd9);
    n_checks++;
    if (ringing !== 1'b0) begin n_fail++; $display("FAIL no_ring_0729 got %b exp 0", ringing); end
    set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    n_checks++;
    if ({ringing, buzzer} !== 2'b11) begin n_fail++; $display("FAIL ring_start got %b exp 11", {ringing, buzzer}); end
    pulse(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ringing, buzzer} !== 2'b10) begin n_fail++; $display("FAIL beep_tick1 got %b exp 10", {ringing, buzzer}); end
    pulse(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ringing, buzzer} !== 2'b11) begin n_fail++; $display("FAIL beep_tick2 got %b exp 11", {ringing, buzzer}); end
    repeat (57) pulse(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ringing, buzzer} !== 2'b10) begin n_fail++; $display("FAIL tick59 got %b exp 10", {ringing, buzzer}); end
    pulse(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ringing, buzzer} !== 2'b00) begin n_fail++; $display("FAIL timeout got %b exp 00", {ringing, buzzer}); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (ringing !== 1'b0) begin n_fail++; $display("FAIL no_retrigger got %b exp 0", ringing); end
  endtask

  task automatic test_stop;
    make_ring;
    n_checks++;
    if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_again got %b exp 1", ringing); end
    pulse(0, 0, 0, 1, 0, 0);
    n_checks++;
    if ({ringing, buzzer} !== 2'b00) begin n_fail++; $display("FAIL stop got %b exp 00", {ringing, buzzer}); end
    set_time(2'd0, 4'd7, 4'd3, 4'd1, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ringing !== 1'b0) begin n_fail++; $display("FAIL no_ring_0731 got %b exp 0", ringing); end
  endtask

  task automatic test_stop_and_snooze;
    make_ring;
    pulse(0, 0, 0, 1, 1, 0);
    n_checks++;
    if ({ringing, snoozing, buzzer} !== 3'b000) begin
      n_fail++; $display("FAIL stop_snooze got %b exp 000", {ringing, snoozing, buzzer});
    end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze;
    make_ring;
    pulse(0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({ringing, snoozing, buzzer} !== 3'b010) begin
      n_fail++; $display("FAIL snooze1 got %b exp 010", {ringing, snoozing, buzzer});
    end
    repeat (4) pulse(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ringing, snoozing} !== 2'b01) begin n_fail++; $display("FAIL snooze_4tick got %b exp 01", {ringing, snoozing}); end
    pulse(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ringing, snoozing, buzzer} !== 3'b101) begin
      n_fail++; $display("FAIL resume1 got %b exp 101", {ringing, snoozing, buzzer});
    end
    pulse(0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({ringing, snoozing} !== 2'b01) begin n_fail++; $display("FAIL snooze2 got %b exp 01", {ringing, snoozing}); end
    repeat (5) pulse(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({ringing, snoozing} !== 2'b10) begin n_fail++; $display("FAIL resume2 got %b exp 10", {ringing, snoozing}); end
    pulse(0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({ringing, snoozing} !== 2'b10) begin n_fail++; $display("FAIL snooze3_ignored got %b exp 10", {ringing, snoozing}); end
    pulse(0, 0, 0, 1, 0, 0);
    make_ring;
    pulse(0, 0, 0, 0, 1, 0);
    n_checks++;
    if (snoozing !== 1'b1) begin n_fail++; $display("FAIL snooze_new_event got %b exp 1", snoozing); end
    alarm_on = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ringing, snoozing, buzzer} !== 3'b000) begin
      n_fail++; $display("FAIL off_in_snooze got %b exp 000", {ringing, snoozing, buzzer});
    end
    alarm_on = 1'b1;
    @(negedge clk);
  endtask
`else
  task automatic test_snooze;
    make_ring;
    pulse(0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({ringing, snoozing, buzzer} !== 3'b101) begin
      n_fail++; $display("FAIL snooze_ignored got %b exp 101", {ringing, snoozing, buzzer});
    end
    alarm_on = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ringing, snoozing, buzzer} !== 3'b000) begin
      n_fail++; $display("FAIL off_in_ring got %b exp 000", {ringing, snoozing, buzzer});
    end
    alarm_on = 1'b1;
    @(negedge clk);
  endtask
`endif

  task automatic test_async_reset;
    make_ring;
    n_checks++;
    if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_before_rst got %b exp 1", ringing); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ringing, snoozing, buzzer, set_field} !== 4'b0000 ||
        {al_hour_ten, al_hour_unit, al_min_ten, al_min_unit} !== 14'd0) begin
      n_fail++; $display("FAIL async_rst got %b %h exp 0000 0000", {ringing, snoozing, buzzer, set_field},
                         {al_hour_ten, al_hour_unit, al_min_ten, al_min_unit});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hour_wrap;
    set_mode = 1'b1;
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({al_hour_ten, al_hour_unit} !== {2'd2, 4'd3}) begin
      n_fail++; $display("FAIL hour_dn_wrap got %h%h exp 23", al_hour_ten, al_hour_unit);
    end
    pulse(0, 1, 0, 0, 0, 0);
    n_checks++;
    if ({al_hour_ten, al_hour_unit} !== {2'd0, 4'd0}) begin
      n_fail++; $display("FAIL hour_up_wrap got %h%h exp 00", al_hour_ten, al_hour_unit);
    end
    pulse(0, 1, 1, 0, 0, 0);
    n_checks++;
    if ({al_hour_ten, al_hour_unit, al_min_ten, al_min_unit} !== 14'd0) begin
      n_fail++; $display("FAIL up_and_down got %h exp 0000", {al_hour_ten, al_hour_unit, al_min_ten, al_min_unit});
    end
    pulse(1, 1, 0, 0, 0, 0);
    n_checks++;
    if ({set_field, al_hour_ten, al_hour_unit, al_min_ten, al_min_unit} !== {1'b0, 2'd0, 4'd1, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL sel_with_up got f%b %h%h:%h%h exp f0 01:00", set_field,
                         al_hour_ten, al_hour_unit, al_min_ten, al_min_unit);
    end
    set_mode = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_edit;
    test_ring;
    test_stop;
    test_stop_and_snooze;
    test_snooze;
    test_async_reset;
    test_hour_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
